// File: rtl/axil_mem_slave.sv
// AXI4-Lite single-port memory slave with fixed read/write latencies and write-first collisions.
// Optional macro AXIL_MEM_RANGE_CHECK_EN: out-of-range addresses answer SLVERR instead of wrapping.
module axil_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 4096,
  parameter int RD_LATENCY = 4,
  parameter int WR_LATENCY = 2
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);
  localparam int         IDX_W       = $clog2(MEM_DEPTH);
  localparam logic [3:0] WR_LOAD     = 4'(WR_LATENCY - 1);
  localparam logic [3:0] RD_LOAD     = 4'(RD_LATENCY - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HALF, W_LAT, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_LAT, R_RESP} r_state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_e              w_state_q, w_state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [IDX_W-1:0]      waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic                  werr_q, werr_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  awready_q, awready_d, wready_q, wready_d;

  r_state_e              r_state_q, r_state_d;
  logic [3:0]            rcnt_q, rcnt_d;
  logic [IDX_W-1:0]      raddr_q, raddr_d;
  logic                  rerr_q, rerr_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  arready_q, arready_d;

  logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s, mem_we_s, rsample_s;
  logic                  aw_err_s, ar_err_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic                  addr_unused_s;

  assign aw_hs_s       = awvalid && awready_q;
  assign w_hs_s        = wvalid && wready_q;
  assign ar_hs_s       = arvalid && arready_q;
  assign addr_unused_s = ^{awaddr, araddr};

`ifdef AXIL_MEM_RANGE_CHECK_EN
  assign aw_err_s = |awaddr[ADDR_WIDTH-1:IDX_W+2];
  assign ar_err_s = |araddr[ADDR_WIDTH-1:IDX_W+2];
`else
  assign aw_err_s = 1'b0;
  assign ar_err_s = 1'b0;
`endif

  // Write channel: collect AW and W in either order, wait out the latency, then respond.
  always_comb begin
    w_state_d = w_state_q;
    wcnt_d    = wcnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    waddr_d   = waddr_q;
    wdat_d    = wdat_q;
    werr_d    = werr_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    commit_s  = 1'b0;
    case (w_state_q)
      W_IDLE, W_HALF: begin
        if (aw_hs_s) begin
          waddr_d   = awaddr[IDX_W+1:2];
          werr_d    = aw_err_s;
          aw_done_d = 1'b1;
        end else begin
        end
        if (w_hs_s) begin
          wdat_d   = wdata;
          w_done_d = 1'b1;
        end else begin
        end
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (WR_LOAD == 4'd0) begin
            commit_s = 1'b1;
          end else begin
            w_state_d = W_LAT;
            wcnt_d    = WR_LOAD;
          end
        end else if (aw_done_d || w_done_d) begin
          w_state_d = W_HALF;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_LAT: begin
        if (wcnt_q <= 4'd1) begin
          commit_s = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
        end else begin
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    if (commit_s) begin
      w_state_d = W_RESP;
      wcnt_d    = 4'd0;
      bvalid_d  = 1'b1;
      bresp_d   = werr_d ? RESP_SLVERR : RESP_OKAY;
    end else begin
    end
    mem_we_s  = commit_s && !werr_d;
    awready_d = (w_state_d == W_IDLE) || ((w_state_d == W_HALF) && !aw_done_d);
    wready_d  = (w_state_d == W_IDLE) || ((w_state_d == W_HALF) && !w_done_d);
  end

  assign rd_idx_s = (r_state_q == R_IDLE) ? araddr[IDX_W+1:2] : raddr_q;

  // Array read port, forwarding a same-edge write so collisions return the new data.
  always_comb begin
    if (mem_we_s && (waddr_d == rd_idx_s)) begin
      rd_word_s = wdat_d;
    end else begin
      rd_word_s = mem[rd_idx_s];
    end
  end

  // Read channel: accept AR, count down, sample the array, hold the response until rready.
  always_comb begin
    r_state_d = r_state_q;
    rcnt_d    = rcnt_q;
    raddr_d   = raddr_q;
    rerr_d    = rerr_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rsample_s = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          raddr_d = araddr[IDX_W+1:2];
          rerr_d  = ar_err_s;
          if (RD_LOAD == 4'd0) begin
            rsample_s = 1'b1;
          end else begin
            r_state_d = R_LAT;
            rcnt_d    = RD_LOAD;
          end
        end else begin
        end
      end
      R_LAT: begin
        if (rcnt_q <= 4'd1) begin
          rsample_s = 1'b1;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      R_RESP: begin
        if (rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          rdata_d   = {DATA_WIDTH{1'b0}};
          rresp_d   = RESP_OKAY;
        end else begin
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (rsample_s) begin
      r_state_d = R_RESP;
      rcnt_d    = 4'd0;
      rvalid_d  = 1'b1;
      rdata_d   = rerr_d ? {DATA_WIDTH{1'b0}} : rd_word_s;
      rresp_d   = rerr_d ? RESP_SLVERR : RESP_OKAY;
    end else begin
    end
    arready_d = (r_state_d == R_IDLE);
  end

  // State and output registers; reset aborts in-flight work in both channels.
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      wcnt_q    <= 4'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      waddr_q   <= {IDX_W{1'b0}};
      wdat_q    <= {DATA_WIDTH{1'b0}};
      werr_q    <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      r_state_q <= R_IDLE;
      rcnt_q    <= 4'd0;
      raddr_q   <= {IDX_W{1'b0}};
      rerr_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= {DATA_WIDTH{1'b0}};
      rresp_q   <= RESP_OKAY;
      arready_q <= 1'b1;
    end else begin
      w_state_q <= w_state_d;
      wcnt_q    <= wcnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      waddr_q   <= waddr_d;
      wdat_q    <= wdat_d;
      werr_q    <= werr_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      r_state_q <= r_state_d;
      rcnt_q    <= rcnt_d;
      raddr_q   <= raddr_d;
      rerr_q    <= rerr_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      arready_q <= arready_d;
    end
  end

  // Array write port; contents survive reset.
  always_ff @(posedge aclk) begin
    if (mem_we_s && !areset) begin
      mem[waddr_d] <= wdat_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
endmodule

// File: tb/tb_axil_mem_slave.sv
// Randomized self-checking bench for axil_mem_slave against a word-array reference model
// with explicit handshake-to-response timing.
module tb_axil_mem_slave;
  localparam int DEPTH  = 4096;
  localparam int WR_LAT = 2;
  localparam int RD_LAT = 4;
  localparam int POOL   = 72;
`ifdef AXIL_MEM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int          cyc = 0;
  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] model_mem [DEPTH];
  bit          pend_v = 1'b0;
  int          pend_idx, pend_cyc;
  logic [31:0] pend_data;

  axil_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
                   .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit is_err(input logic [31:0] a);
    return RANGE_EN && (a >= 32'(DEPTH * 4));
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom_range(0, POOL - 1) << 2) | $urandom_range(0, 3);
    if ($urandom_range(0, 3) == 0) a = a | ($urandom_range(1, 15) << 14);
    return a;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_pend, w_pend, aw_hs, w_hs, seen, err;
    int k, m, t_done, tcur, idx;
    aw_pend = 1'b1; w_pend = 1'b1; k = 0; t_done = 0;
    err = is_err(addr); idx = widx(addr);
    while ((aw_pend || w_pend) && k < 64) begin
      @(negedge aclk);
      awvalid = aw_pend && (k >= aw_dly); awaddr = addr;
      wvalid  = w_pend && (k >= w_dly);   wdata  = data;
      if (!aw_pend) check_eq("wr_awready_half", awready, 0);
      if (!w_pend)  check_eq("wr_wready_half", wready, 0);
      aw_hs = awvalid && awready; w_hs = wvalid && wready; tcur = cyc;
      @(posedge aclk);
      if (aw_hs) aw_pend = 1'b0;
      if (w_hs) w_pend = 1'b0;
      if (aw_hs || w_hs) t_done = tcur;
      k++;
    end
    check_eq("wr_handshake", aw_pend | w_pend, 0);
    if (aw_pend || w_pend) begin
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    pend_v = !err; pend_idx = idx; pend_data = data; pend_cyc = t_done + WR_LAT - 1;
    seen = 1'b0; m = 0;
    while (!seen && m < 40) begin
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0;
      if (bvalid) seen = 1'b1;
      else begin
        check_eq("wr_awready_busy", awready, 0);
        m++;
      end
    end
    check_eq("wr_bvalid_seen", seen, 1);
    if (!seen) return;
    check_eq("wr_latency", cyc - t_done, WR_LAT);
    check_eq("wr_bresp", bresp, err ? 2'b10 : 2'b00);
    if (!err) model_mem[idx] = data;
    pend_v = 1'b0;
    for (int j = 0; j < b_dly; j++) begin
      @(posedge aclk); @(negedge aclk);
      check_eq("wr_bvalid_hold", bvalid, 1);
      check_eq("wr_bresp_hold", bresp, err ? 2'b10 : 2'b00);
      check_eq("wr_awready_hold", awready, 0);
    end
    bready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    bready = 1'b0;
    check_eq("wr_bvalid_drop", bvalid, 0);
    check_eq("wr_awready_idle", awready, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                         output logic [31:0] got);
    bit ar_pend, ar_hs, seen, err, fwd;
    int k, m, t_done, tcur, idx;
    logic [31:0] exp_d;
    got = 32'h0; ar_pend = 1'b1; k = 0; t_done = 0;
    err = is_err(addr); idx = widx(addr);
    while (ar_pend && k < 64) begin
      @(negedge aclk);
      arvalid = (k >= ar_dly); araddr = addr;
      ar_hs = arvalid && arready; tcur = cyc;
      @(posedge aclk);
      if (ar_hs) begin ar_pend = 1'b0; t_done = tcur; end
      k++;
    end
    check_eq("rd_handshake", ar_pend, 0);
    if (ar_pend) begin arvalid = 1'b0; return; end
    seen = 1'b0; m = 0;
    while (!seen && m < 40) begin
      @(negedge aclk);
      arvalid = 1'b0;
      if (rvalid) seen = 1'b1;
      else begin
        check_eq("rd_rdata_idle", rdata, 0);
        check_eq("rd_arready_busy", arready, 0);
        m++;
      end
    end
    check_eq("rd_rvalid_seen", seen, 1);
    if (!seen) return;
    check_eq("rd_latency", cyc - t_done, RD_LAT);
    fwd = pend_v && (pend_idx == idx) && (pend_cyc <= t_done + RD_LAT - 1);
    exp_d = err ? 32'h0 : (fwd ? pend_data : model_mem[idx]);
    got = rdata;
    check_eq("rd_data", rdata, exp_d);
    check_eq("rd_rresp", rresp, err ? 2'b10 : 2'b00);
    for (int j = 0; j < r_dly; j++) begin
      @(posedge aclk); @(negedge aclk);
      check_eq("rd_rvalid_hold", rvalid, 1);
      check_eq("rd_rdata_hold", rdata, exp_d);
      check_eq("rd_arready_hold", arready, 0);
    end
    rready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    rready = 1'b0;
    check_eq("rd_rvalid_drop", rvalid, 0);
    check_eq("rd_rdata_zero", rdata, 0);
    check_eq("rd_arready_idle", arready, 1);
  endtask

  initial begin
    logic [31:0] got, old, wa, ra;
    int t0;
    awaddr = 32'h0; awvalid = 1'b0; wdata = 32'h0; wvalid = 1'b0; bready = 1'b0;
    araddr = 32'h0; arvalid = 1'b0; rready = 1'b0; areset = 1'b1;
    repeat (3) @(negedge aclk);
    check_eq("rst_awready", awready, 1);
    check_eq("rst_wready", wready, 1);
    check_eq("rst_arready", arready, 1);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_bresp", bresp, 0);
    check_eq("rst_rresp", rresp, 0);
    check_eq("rst_rdata", rdata, 0);
    areset = 1'b0;

    for (int i = 0; i < POOL; i++) do_write(32'(i * 4), $urandom, 0, 0, 0);

    do_write(32'h100, 32'hDEADBEEF, 0, 0, 0);
    do_read(32'h100, 0, 0, got);
    check_eq("dir_wr_rd", got, 32'hDEADBEEF);

    do_write(32'h8, 32'h1234, 3, 0, 0);
    do_read(32'h8, 0, 0, got);
    check_eq("dir_split", got, 32'h1234);

    do_write(32'h40, 32'h0BADF00D, 0, 0, 0);
    fork
      do_read(32'h40, 0, 0, got);
      do_write(32'h40, 32'hA5A5A5A5, 2, 2, 0);
    join
    check_eq("dir_collision", got, 32'hA5A5A5A5);

    do_read(32'h4000, 0, 0, got);
    check_eq("dir_range", got, RANGE_EN ? 32'h0 : model_mem[0]);

    do_write(32'h10, 32'hCAFE0001, 1, 0, 10);
    do_read(32'h10, 0, 10, got);

    old = model_mem[5];
    @(negedge aclk);
    awvalid = 1'b1; awaddr = 32'h14; wvalid = 1'b1; wdata = ~old;
    check_eq("rst_mid_aw_ready", awready & wready, 1);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    check_eq("rst_mid_awready", awready, 1);
    check_eq("rst_mid_wready", wready, 1);
    for (int j = 0; j < 4; j++) begin
      check_eq("rst_mid_no_bvalid", bvalid, 0);
      @(negedge aclk);
    end
    do_read(32'h14, 0, 0, got);
    check_eq("rst_mid_unchanged", got, old);

    for (int it = 0; it < 60; it++) begin
      wa = rand_addr(); ra = rand_addr(); t0 = $urandom_range(0, 2);
      case (t0)
        0: do_write(wa, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        1: do_read(ra, $urandom_range(0, 2), $urandom_range(0, 3), got);
        default: fork
          do_write(wa, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
          do_read(ra, $urandom_range(0, 3), $urandom_range(0, 2), got);
        join
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
